alu_arbiter: RTL and testbench

Shares the single combinational 32-bit ALU between two requesters (req0, req1) with valid/ready handshakes. Round-robin arbitration picks one request per cycle, computes it, and holds the result in a one-entry response register. The response goes out on one tagged valid/ready channel. It sits between the two issue ports of the multi-cycle datapath and the shared ALU.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu.sv | 31 +++
 rtl/alu_arbiter.sv | 101 ++++++++++
 tb/tb_alu_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, opcode legality check and the
// requester-id type used by the arbiter and the ALU datapath.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Identifies which issue port produced a response (0 or 1).
  typedef logic req_id_t;

  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: op_legal = 1'b1;
      default:                                    op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU: AND, OR, wrapping ADD/SUB and unsigned SLT.
// Unlisted opcodes produce zero.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven,
    // so no latch is inferred for opcodes the case does not list.
    result = '0;
    case (op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, (a < b)};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters, with a one-entry
// tagged response register. Define ALU_ARB_ILLEGAL_OP_EN to flag illegal opcodes on rsp_err.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_q;
  req_id_t          last_grant_q;
  req_id_t          grant;
  logic             grant_valid;
  logic             can_accept;
  logic             accept;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  // On contention the requester that did not win last time gets the ALU.
  assign grant_valid = req0_valid | req1_valid;
  assign grant       = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  assign can_accept  = (state_q == EMPTY) || rsp_ready;
  assign accept      = can_accept && grant_valid;

  // Readies are forced low while reset is asserted, not just after release.
  assign req0_ready  = rst_n && accept && (grant == 1'b0);
  assign req1_ready  = rst_n && accept && (grant == 1'b1);

  assign alu_op = grant ? req1_op : req0_op;
  assign alu_a  = grant ? req1_a  : req0_a;
  assign alu_b  = grant ? req1_b  : req0_b;

  alu #(.WIDTH(WIDTH)) u_alu (
    .op     (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_result),
    .zero   (alu_zero)
  );

  assign rsp_valid = (state_q == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the response fields are reset too, since their post-reset
      // values are visible to the consumer; last_grant starts at 1 so req0
      // wins the first contention.
      state_q      <= EMPTY;
      last_grant_q <= 1'b1;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
    end else if (accept) begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q      <= FULL;
      last_grant_q <= grant;
      rsp_id       <= grant;
      rsp_result   <= alu_result;
      rsp_zero     <= alu_zero;
    end else if (state_q == FULL && rsp_ready) begin
      state_q <= EMPTY;
    end
  end

`ifdef ALU_ARB_ILLEGAL_OP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err <= 1'b0;
    end else if (accept) begin
      rsp_err <= ~op_legal(alu_op);
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_alu_arbiter;

  localparam int W = 32;

`ifdef ALU_ARB_ILLEGAL_OP_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [2:0]   req0_op = '0, req1_op = '0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_zero, rsp_err;
  logic [W-1:0] rsp_result;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model of the response slot and the round-robin pointer.
  logic         m_valid, m_id, m_zero, m_err, m_last;
  logic [W-1:0] m_result;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] ref_result(input logic [2:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return (a < b) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [2:0] op);
    return !(op inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111});
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_id = 1'b0; m_result = '0; m_zero = 1'b0; m_err = 1'b0; m_last = 1'b1;
  endtask

  task automatic compare_outputs();
    check("rsp_valid", rsp_valid, m_valid);
    if (m_valid) begin
      check("rsp_id", rsp_id, m_id);
      check("rsp_result", rsp_result, m_result);
      check("rsp_zero", rsp_zero, m_zero);
      check("rsp_err", rsp_err, m_err);
    end
  endtask

  // One clock: entered just after a negedge with inputs already driven.
  // Checks readies, advances the model at the edge, checks outputs at the
  // following negedge. Reports which requester the model says was accepted.
  task automatic cycle(output logic acc0, output logic acc1);
    logic         any, pick, can, drain;
    logic [2:0]   op;
    logic [W-1:0] a, b, r;
    #1;
    any   = req0_valid || req1_valid;
    pick  = (req0_valid && req1_valid) ? ~m_last : req1_valid;
    can   = !m_valid || rsp_ready;
    drain = m_valid && rsp_ready;
    acc0  = can && any && !pick;
    acc1  = can && any && pick;
    check("req0_ready", req0_ready, acc0);
    check("req1_ready", req1_ready, acc1);
    op = pick ? req1_op : req0_op;
    a  = pick ? req1_a  : req0_a;
    b  = pick ? req1_b  : req0_b;
    @(posedge clk);
    if (acc0 || acc1) begin
      r        = ref_result(op, a, b);
      m_valid  = 1'b1;
      m_id     = pick;
      m_result = r;
      m_zero   = (r == '0);
      m_err    = ERR_EN && ref_illegal(op);
      m_last   = pick;
    end else if (drain) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    compare_outputs();
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return W'($urandom_range(0, 15));
      1:       return 32'hFFFF_FFFF - W'($urandom_range(0, 3));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    logic a0, a1;
    model_reset();

    // Reset state, with both requesters already asserting valid.
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #2;
    check("rst_req0_ready", req0_ready, 1'b0);
    check("rst_req1_ready", req1_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id", rsp_id, 1'b0);
    check("rst_rsp_result", rsp_result, '0);
    check("rst_rsp_zero", rsp_zero, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Contention right after reset: req0 first, then alternation.
    req0_valid = 1'b1; req0_op = 3'b110; req0_a = 32'd9;    req0_b = 32'd9;
    req1_valid = 1'b1; req1_op = 3'b001; req1_a = 32'hF0;   req1_b = 32'h0F;
    cycle(a0, a1);
    check("cont1_id", rsp_id, 1'b0);
    check("cont1_result", rsp_result, 32'd0);
    check("cont1_zero", rsp_zero, 1'b1);
    cycle(a0, a1);
    check("cont2_id", rsp_id, 1'b1);
    check("cont2_result", rsp_result, 32'hFF);
    check("cont2_zero", rsp_zero, 1'b0);
    cycle(a0, a1);
    check("cont3_id", rsp_id, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    cycle(a0, a1);
    check("cont_drained", rsp_valid, 1'b0);

    // Single request.
    req0_valid = 1'b1; req0_op = 3'b010; req0_a = 32'd5; req0_b = 32'd7;
    cycle(a0, a1);
    check("single_valid", rsp_valid, 1'b1);
    check("single_id", rsp_id, 1'b0);
    check("single_result", rsp_result, 32'd12);
    check("single_zero", rsp_zero, 1'b0);
    req0_valid = 1'b0;

    // Backpressure while the ADD result is held.
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_op = 3'b111; req1_a = 32'd3; req1_b = 32'd4;
    repeat (3) begin
      cycle(a0, a1);
      check("bp_held_result", rsp_result, 32'd12);
      check("bp_req1_ready", req1_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    cycle(a0, a1);
    check("bp_new_id", rsp_id, 1'b1);
    check("bp_new_result", rsp_result, 32'd1);
    req1_valid = 1'b0;
    cycle(a0, a1);

    // Wrap-around add, unsigned compare, unlisted opcode.
    req0_valid = 1'b1; req0_op = 3'b010; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1;
    cycle(a0, a1);
    check("wrap_result", rsp_result, 32'd0);
    check("wrap_zero", rsp_zero, 1'b1);
    req0_op = 3'b111;
    cycle(a0, a1);
    check("slt_unsigned_result", rsp_result, 32'd0);
    check("slt_unsigned_zero", rsp_zero, 1'b1);
    req0_op = 3'b100; req0_a = 32'd5; req0_b = 32'd3;
    cycle(a0, a1);
    check("illegal_result", rsp_result, 32'd0);
    check("illegal_zero", rsp_zero, 1'b1);
    check("illegal_err", rsp_err, ERR_EN);
    req0_op = 3'b000; req0_a = 32'hFF; req0_b = 32'hF0;
    cycle(a0, a1);
    check("and_result", rsp_result, 32'hF0);
    req0_valid = 1'b0;

    // Reset mid-flight while FULL.
    check("pre_reset_full", rsp_valid, 1'b1);
    #2 rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("midrst_rsp_valid", rsp_valid, 1'b0);
    check("midrst_rsp_result", rsp_result, '0);
    check("midrst_req0_ready", req0_ready, 1'b0);
    check("midrst_req1_ready", req1_ready, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    req0_op = 3'b010; req0_a = 32'd1; req0_b = 32'd2;
    req1_op = 3'b010; req1_a = 32'd3; req1_b = 32'd4;
    cycle(a0, a1);
    check("postrst_id", rsp_id, 1'b0);
    check("postrst_result", rsp_result, 32'd3);
    req0_valid = 1'b0; req1_valid = 1'b0;
    cycle(a0, a1);

    // Randomized traffic; a request is held unchanged until it is accepted.
    for (int i = 0; i < 3000; i++) begin
      if (!req0_valid) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_op    = 3'($urandom_range(0, 7));
        req0_a     = rand_operand();
        req0_b     = ($urandom_range(0, 5) == 0) ? req0_a : rand_operand();
      end
      if (!req1_valid) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_op    = 3'($urandom_range(0, 7));
        req1_a     = rand_operand();
        req1_b     = ($urandom_range(0, 5) == 0) ? req1_a : rand_operand();
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle(a0, a1);
      if (a0) req0_valid = 1'b0;
      if (a1) req1_valid = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
